// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states,
// recode digit encodings and the iteration-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } digit_e;

  // Operands are extended by two bits, so K = (N+2)/2 radix-4 digits.
  function automatic int calc_iters(input int n);
    return n / 2 + 1;
  endfunction

  function automatic digit_e recode(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return P1;
      3'b011:         return P2;
      3'b100:         return M2;
      3'b101, 3'b110: return M1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: maps {Q[1:0], q_m1} to the W-bit
// addend 0, +M, +2M, -M or -2M (two's complement, modulo 2^W).
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [2:0]   bits_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] addend_o
);

  digit_e digit;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    addend_o = '0;
    digit    = recode(bits_i);
    case (digit)
      P1:      addend_o = m_i;
      P2:      addend_o = m_i << 1;
      M1:      addend_o = -m_i;
      M2:      addend_o = -(m_i << 1);
      default: addend_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mul.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation,
// retiring two multiplier bits per cycle with a start/busy/done handshake.
module booth_radix4_mul
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   data_M,
  input  logic [N-1:0]   data_Q,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] data_out
);

  localparam int W  = N + 2;
  localparam int K  = calc_iters(N);
  localparam int CW = $clog2(K + 1);

  if ((N % 2) != 0 || N < 4) begin : g_bad_width
    $error("booth_radix4_mul: N must be even and >= 4");
  end

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [W-1:0]     m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   out_q, out_d;

  logic [W-1:0]     m_ext, q_ext;
  logic [W-1:0]     addend, sum;
  logic [W-1:0]     a_sh, q_sh;
  logic [2*W-1:0]   aq_sh;

  // Two extra bits make unsigned operands positive and keep +/-2M exact.
  assign m_ext = signed_mode ? {{2{data_M[N-1]}}, data_M} : {2'b00, data_M};
  assign q_ext = signed_mode ? {{2{data_Q[N-1]}}, data_Q} : {2'b00, data_Q};

  booth_r4_recoder #(.W(W)) u_recoder (
    .bits_i   ({q_q[1:0], qm1_q}),
    .m_i      (m_q),
    .addend_o (addend)
  );

  assign sum   = a_q + addend;
  assign a_sh  = {{2{sum[W-1]}}, sum[W-1:2]};
  assign q_sh  = {sum[1:0], q_q[W-1:2]};
  assign aq_sh = {a_sh, q_sh};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = '0;
          q_d     = q_ext;
          qm1_d   = 1'b0;
          m_d     = m_ext;
          cnt_d   = CW'(K);
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q_q[1];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          out_d   = aq_sh[2*N-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign busy     = (state_q == CALC);
  assign done     = (state_q == DONE);
  assign data_out = out_q;

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Self-checking bench for booth_radix4_mul at N=8, 4 and 16: a cycle-level
// behavioural model per instance plus directed literal checks.
module tb_booth_radix4_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a [3];
  logic        sm_a    [3];
  logic [15:0] m_a     [3];
  logic [15:0] q_a     [3];

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Reference product: plain integer multiply of the n-bit operands,
  // interpreted signed or unsigned, truncated to 2n bits.
  function automatic logic [63:0] ref_prod(int n, bit sm, logic [15:0] a, logic [15:0] b);
    longint x, y, mask;
    mask = (longint'(1) << n) - 1;
    x = longint'(a) & mask;
    y = longint'(b) & mask;
    if (sm && x >= (longint'(1) << (n - 1))) x = x - (longint'(1) << n);
    if (sm && y >= (longint'(1) << (n - 1))) y = y - (longint'(1) << n);
    return 64'((x * y) & ((longint'(1) << (2 * n)) - 1));
  endfunction

  for (genvar g = 0; g < 3; g++) begin : blk
    localparam int NN = (g == 0) ? 8 : ((g == 1) ? 4 : 16);
    localparam int KK = NN / 2 + 1;

    logic            busy, done;
    logic [2*NN-1:0] dout;
    logic [63:0]     got_out;
    logic [63:0]     exp_out;
    logic [63:0]     pend;
    logic            exp_done;
    logic            exp_busy;
    int              left = 0;

    booth_radix4_mul #(.N(NN)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start_a[g]),
      .signed_mode (sm_a[g]),
      .data_M      (m_a[g][NN-1:0]),
      .data_Q      (q_a[g][NN-1:0]),
      .busy        (busy),
      .done        (done),
      .data_out    (dout)
    );

    assign got_out  = 64'(dout);
    assign exp_busy = (left != 0);

    // Model: an accepted request occupies KK busy cycles, then the product
    // appears with a one-cycle done; ready whenever nothing is outstanding.
    always @(posedge clk) begin
      if (rst) begin
        left     <= 0;
        exp_done <= 1'b0;
        exp_out  <= '0;
        pend     <= '0;
      end else if (left == 0 && start_a[g]) begin
        left     <= KK;
        pend     <= ref_prod(NN, sm_a[g], m_a[g], q_a[g]);
        exp_done <= 1'b0;
      end else if (left > 0) begin
        left     <= left - 1;
        exp_done <= (left == 1);
        if (left == 1) exp_out <= pend;
      end else begin
        exp_done <= 1'b0;
      end
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic logic get_done(int idx);
    case (idx)
      0: return blk[0].done;
      1: return blk[1].done;
      default: return blk[2].done;
    endcase
  endfunction

  function automatic logic get_busy(int idx);
    case (idx)
      0: return blk[0].busy;
      1: return blk[1].busy;
      default: return blk[2].busy;
    endcase
  endfunction

  function automatic logic [63:0] get_out(int idx);
    case (idx)
      0: return blk[0].got_out;
      1: return blk[1].got_out;
      default: return blk[2].got_out;
    endcase
  endfunction

  task automatic cmp_inst(string tag, logic gb, logic eb, logic gd, logic ed,
                          logic [63:0] go, logic [63:0] eo);
    check({tag, " busy"}, 64'(gb), 64'(eb));
    check({tag, " done"}, 64'(gd), 64'(ed));
    check({tag, " data_out"}, go, eo);
  endtask

  // One clock: pass a rising edge, then compare every instance at the
  // falling edge. Inputs are changed by callers right after this returns.
  task automatic step();
    @(negedge clk);
    if (cmp_en) begin
      cmp_inst("n8",  blk[0].busy, blk[0].exp_busy, blk[0].done, blk[0].exp_done,
               blk[0].got_out, blk[0].exp_out);
      cmp_inst("n4",  blk[1].busy, blk[1].exp_busy, blk[1].done, blk[1].exp_done,
               blk[1].got_out, blk[1].exp_out);
      cmp_inst("n16", blk[2].busy, blk[2].exp_busy, blk[2].done, blk[2].exp_done,
               blk[2].got_out, blk[2].exp_out);
    end
  endtask

  // Issue one request with a single-cycle start; returns the number of rising
  // edges from raising start (sampling edge included) to done, busy cycles
  // seen and the result.
  task automatic run_op(int idx, bit sm, logic [15:0] a, logic [15:0] b,
                        output int edges, output int busy_cyc, output logic [63:0] res);
    bit seen = 1'b0;
    sm_a[idx]    = sm;
    m_a[idx]     = a;
    q_a[idx]     = b;
    start_a[idx] = 1'b1;
    edges    = 0;
    busy_cyc = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      edges++;
      start_a[idx] = 1'b0;
      if (get_busy(idx)) busy_cyc++;
      if (get_done(idx)) seen = 1'b1;
    end
    if (!seen) check("done timeout", 64'd0, 64'd1);
    res = get_out(idx);
  endtask

  task automatic directed(string name, int idx, int n, bit sm, logic [15:0] a,
                          logic [15:0] b, logic [63:0] lit, int exp_edges);
    int e, bc;
    logic [63:0] r;
    check({name, " model"}, ref_prod(n, sm, a, b), lit);
    run_op(idx, sm, a, b, e, bc, r);
    check({name, " result"}, r, lit);
    check({name, " latency"}, 64'(e), 64'(exp_edges));
  endtask

  initial begin
    int          e, bc, cnt;
    bit          seen;
    logic [63:0] r;
    logic [15:0] ra, rb;
    bit          rs;
    logic [15:0] corner_a [5];
    logic [15:0] corner_b [5];
    bit          corner_s [5];
    int          widths   [3];

    widths = '{8, 4, 16};
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      sm_a[i]    = 1'b0;
      m_a[i]     = '0;
      q_a[i]     = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset busy", 64'(blk[0].busy), 64'd0);
    check("reset done", 64'(blk[0].done), 64'd0);
    check("reset data_out", blk[0].got_out, 64'd0);
    rst = 1'b0;

    // Basic signed op with latency and busy-length checks.
    run_op(0, 1'b1, 16'h00FA, 16'h00FD, e, bc, r);
    check("-6x-3 result", r, 64'h0012);
    check("-6x-3 latency", 64'(e), 64'd6);
    check("-6x-3 busy cycles", 64'(bc), 64'd5);

    directed("u255x255", 0, 8, 1'b0, 16'h00FF, 16'h00FF, 64'hFE01, 6);
    directed("u200x3",   0, 8, 1'b0, 16'h00C8, 16'h0003, 64'h0258, 6);
    directed("sFFxFF",   0, 8, 1'b1, 16'h00FF, 16'h00FF, 64'h0001, 6);
    directed("s-128x-128", 0, 8, 1'b1, 16'h0080, 16'h0080, 64'h4000, 6);
    directed("s-128x127",  0, 8, 1'b1, 16'h0080, 16'h007F, 64'hC080, 6);
    directed("s0x-1",      0, 8, 1'b1, 16'h0000, 16'h00FF, 64'h0000, 6);

    // start pulsed mid-CALC with other operands is ignored.
    sm_a[0] = 1'b1; m_a[0] = 16'h000B; q_a[0] = 16'h00FB; start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    step();
    m_a[0] = 16'h0064; q_a[0] = 16'h0064; start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = blk[0].done;
    end
    check("ignored start result", blk[0].got_out, 64'hFFC9);

    // start held across DONE: back-to-back without a bubble.
    sm_a[0] = 1'b1; m_a[0] = 16'h0003; q_a[0] = 16'h0004; start_a[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = blk[0].done;
    end
    check("held first result", blk[0].got_out, 64'h000C);
    m_a[0] = 16'h0007; q_a[0] = 16'h00FE;
    seen = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      cnt++;
      seen = blk[0].done;
    end
    start_a[0] = 1'b0;
    check("back-to-back spacing", 64'(cnt), 64'd6);
    check("back-to-back result", blk[0].got_out, 64'hFFF2);
    step();

    // Synchronous reset in the third CALC cycle.
    sm_a[0] = 1'b1; m_a[0] = 16'h0009; q_a[0] = 16'h0009; start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid-op reset busy", 64'(blk[0].busy), 64'd0);
    check("mid-op reset done", 64'(blk[0].done), 64'd0);
    check("mid-op reset data_out", blk[0].got_out, 64'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (blk[0].done) cnt++;
    end
    check("no done after reset", 64'(cnt), 64'd0);
    directed("s5x5 after reset", 0, 8, 1'b1, 16'h0005, 16'h0005, 64'h0019, 6);

    // Narrow and wide instances.
    directed("n4 -6x-3", 1, 4, 1'b1, 16'h000A, 16'h000D, 64'h12, 4);
    directed("n16 -32768^2", 2, 16, 1'b1, 16'h8000, 16'h8000, 64'h4000_0000, 10);
    directed("n16 uFFFF^2",  2, 16, 1'b0, 16'hFFFF, 16'hFFFF, 64'hFFFE_0001, 10);

    // Corners and random operands on every width, both modes.
    for (int w = 0; w < 3; w++) begin
      logic [15:0] mask, minv;
      mask = 16'((32'd1 << widths[w]) - 1);
      minv = 16'(32'd1 << (widths[w] - 1));
      corner_a = '{minv, mask, 16'h0000, mask, minv};
      corner_b = '{minv, mask, mask, mask, mask >> 1};
      corner_s = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int c = 0; c < 5; c++) begin
        run_op(w, corner_s[c], corner_a[c], corner_b[c], e, bc, r);
        check($sformatf("corner w%0d #%0d", widths[w], c), r,
              ref_prod(widths[w], corner_s[c], corner_a[c], corner_b[c]));
      end
      for (int t = 0; t < 40; t++) begin
        rs = 1'($urandom_range(0, 1));
        ra = 16'($urandom) & mask;
        rb = 16'($urandom) & mask;
        run_op(w, rs, ra, rb, e, bc, r);
        check($sformatf("random w%0d #%0d", widths[w], t), r, ref_prod(widths[w], rs, ra, rb));
        check($sformatf("random latency w%0d #%0d", widths[w], t), 64'(e),
              64'(widths[w] / 2 + 2));
      end
    end

    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
